// File: rtl/image_aes_pkg.sv
// Shared constants and types for the image encrypter/decrypter pair.
package image_aes_pkg;

    // XOR key shared by both sides of the link
    localparam logic [7:0] KEY_DEFAULT = 8'hB3;

    // Frame geometry and addressing
    localparam int unsigned IMG_W      = 175;
    localparam int unsigned IMG_H      = 175;
    localparam int unsigned NUM_PIXELS = IMG_W * IMG_H;
    localparam int unsigned ADDR_W     = 15;

    // Frame transfer state encoding
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } xfer_state_e;

    // Byte cipher; XOR is its own inverse so both directions use this
    function automatic logic [7:0] xor_key(input logic [7:0] data, input logic [7:0] key);
        return data ^ key;
    endfunction

endpackage

// File: rtl/xor_cipher_stage.sv
// Registered single-stage XOR cipher with valid/address pass-through.
module xor_cipher_stage #(
    parameter logic [7:0]  KEY    = image_aes_pkg::KEY_DEFAULT,
    parameter int unsigned ADDR_W = image_aes_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [7:0]        out_data
);
    import image_aes_pkg::*;

    logic accept_c;

    assign accept_c = in_valid & ~flush;

    // Transform one byte per cycle; address/data hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= accept_c;
            if (accept_c) begin
                out_addr <= in_addr;
                out_data <= xor_key(in_data, KEY);
            end
        end
    end

endmodule

// File: rtl/image_encrypter.sv
// Streams a plaintext frame from the source RAM, XORs it with the key and
// writes the ciphertext to the destination RAM, with start/busy/done control.
module image_encrypter #(
    parameter logic [7:0]  KEY        = image_aes_pkg::KEY_DEFAULT,
    parameter int unsigned NUM_PIXELS = image_aes_pkg::NUM_PIXELS,
    parameter int unsigned ADDR_W     = image_aes_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        plain_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);
    import image_aes_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    xfer_state_e       state, state_nxt;
    logic              rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              chk_clr;

    // Read-to-write shadow: marks which issued address the RAM is returning
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;

    // Next-state and registered-output decode; abort overrides everything
    always_comb begin
        state_nxt   = state;
        rd_en_nxt   = rd_en;
        rd_addr_nxt = rd_addr;
        busy_nxt    = busy;
        done_nxt    = done;
        chk_clr     = 1'b0;

        if (abort) begin
            state_nxt = ST_IDLE;
            rd_en_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_nxt   = ST_RUN;
                        rd_addr_nxt = '0;
                        rd_en_nxt   = 1'b1;
                        busy_nxt    = 1'b1;
                        done_nxt    = 1'b0;
                        chk_clr     = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rd_en) begin
                        if (rd_addr == LAST_ADDR) begin
                            rd_en_nxt = 1'b0;
                            state_nxt = ST_DRAIN;
                        end else begin
                            rd_addr_nxt = rd_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wr_en && (wr_addr == LAST_ADDR)) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and control output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_en   <= rd_en_nxt;
            rd_addr <= rd_addr_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    // Track the in-flight read across the RAM's one-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= 1'b0;
            pipe_addr  <= '0;
        end else begin
            pipe_valid <= rd_en & ~abort;
            if (rd_en) begin
                pipe_addr <= rd_addr;
            end
        end
    end

    // Running XOR of plaintext bytes that actually reach the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (chk_clr) begin
            checksum <= '0;
        end else if (pipe_valid && !abort) begin
            checksum <= checksum ^ plain_data;
        end
    end

    xor_cipher_stage #(
        .KEY    (KEY),
        .ADDR_W (ADDR_W)
    ) u_cipher (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (pipe_valid),
        .in_addr   (pipe_addr),
        .in_data   (plain_data),
        .out_valid (wr_en),
        .out_addr  (wr_addr),
        .out_data  (wr_data)
    );

endmodule
